// File: rtl/sequenciador_instrucoes_pkg.sv
// Shared definitions for the instruction sequencer and the processor control unit:
// opcode field values, sequencer state encoding and the default EXEC timeout.
package sequenciador_instrucoes_pkg;

  // Opcode lives in instruction bits [8:6]
  typedef enum logic [2:0] {
    OP_MV   = 3'b000,
    OP_MVI  = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_HALT = 3'b111
  } opcode_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_ISSUE = 3'd3,
    ST_EXEC  = 3'd4,
    ST_HALT  = 3'd5,
    ST_ERRO  = 3'd6
  } state_t;

  localparam int TIMEOUT_DEFAULT = 8;

  // Extract the opcode field from an instruction word
  function automatic opcode_t opcode_of(input logic [15:0] instr);
    return opcode_t'(instr[8:6]);
  endfunction

endpackage

// File: rtl/sequenciador_instrucoes_contador_timeout.sv
// Loadable down-counter with a zero flag; used to bound how long the
// sequencer waits for the processor to report Done.
module contador_timeout #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count_reg;

  // Load has priority over decrement; the count saturates at zero
  always_ff @(posedge clk) begin
    if (!resetn) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - WIDTH'(1);
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/sequenciador_instrucoes.sv
// Instruction sequencer: fetches 16-bit words from a synchronous program ROM,
// hands them (plus the immediate for mvi) to the processor on DIN, pulses Run,
// and waits a bounded time for Done before fetching the next instruction.
module sequenciador_instrucoes
  import sequenciador_instrucoes_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Start,
  output logic [ADDR_W-1:0] MemAddr,
  input  logic [15:0]       MemData,
  output logic [15:0]       DIN,
  output logic              Run,
  input  logic              Done,
  output logic              Busy,
  output logic              Halted,
  output logic              Erro,
  output logic [7:0]        InstrCount
);

  // Counter is loaded with TIMEOUT-1 so that it reaches zero in the
  // TIMEOUT-th EXEC cycle.
  localparam int TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT - 1);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [15:0]       din_reg, din_next;
  logic              run_reg, run_next;
  logic [7:0]        count_reg, count_next;
  logic [ADDR_W-1:0] pc_plus1;
  logic [ADDR_W-1:0] mem_addr;
  logic              to_load;
  logic              to_dec;
  logic              to_zero;

  assign pc_plus1 = pc_reg + ADDR_W'(1);

  contador_timeout #(
    .WIDTH(TO_W)
  ) u_contador_timeout (
    .clk       (Clock),
    .resetn    (Resetn),
    .load      (to_load),
    .load_value(TO_LOAD),
    .dec       (to_dec),
    .zero      (to_zero)
  );

  // State, PC, data path and instruction counter registers
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_reg <= ST_IDLE;
      pc_reg    <= '0;
      din_reg   <= '0;
      run_reg   <= 1'b0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      din_reg   <= din_next;
      run_reg   <= run_next;
      count_reg <= count_next;
    end
  end

  // Next-state logic; MemAddr presents PC except while prefetching the word after it
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    din_next   = din_reg;
    run_next   = 1'b0;
    count_next = count_reg;
    mem_addr   = pc_reg;
    to_load    = 1'b0;
    to_dec     = 1'b0;

    unique case (state_reg)
      ST_IDLE, ST_HALT, ST_ERRO: begin
        if (Start) begin
          pc_next    = '0;
          count_next = '0;
          state_next = ST_FETCH;
        end
      end

      ST_FETCH: begin
        mem_addr   = pc_reg;
        state_next = ST_LOAD;
      end

      ST_LOAD: begin
        // Request the following word now so it is ready if this is an mvi
        mem_addr = pc_plus1;
        if (opcode_of(MemData) == OP_HALT) begin
          state_next = ST_HALT;
        end else begin
          din_next   = MemData;
          run_next   = 1'b1;
          state_next = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        mem_addr   = pc_plus1;
        to_load    = 1'b1;
        state_next = ST_EXEC;
        if (opcode_of(din_reg) == OP_MVI) begin
          din_next = MemData;
          pc_next  = pc_reg + ADDR_W'(2);
        end else begin
          pc_next  = pc_plus1;
        end
      end

      ST_EXEC: begin
        // Done wins over a timeout expiring in the same cycle
        if (Done) begin
          count_next = count_reg + 8'd1;
          state_next = ST_FETCH;
        end else if (to_zero) begin
          state_next = ST_ERRO;
        end else begin
          to_dec = 1'b1;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign MemAddr    = mem_addr;
  assign DIN        = din_reg;
  assign Run        = run_reg;
  assign InstrCount = count_reg;
  assign Busy       = (state_reg == ST_FETCH) || (state_reg == ST_LOAD) ||
                      (state_reg == ST_ISSUE) || (state_reg == ST_EXEC);
  assign Halted     = (state_reg == ST_HALT);
  assign Erro       = (state_reg == ST_ERRO);

endmodule

// File: tb/tb_sequenciador_instrucoes.sv
// Self-checking bench for sequenciador_instrucoes: an instruction-level model
// (PC, instruction count, last DIN) predicts what the sequencer must show in
// each phase of every instruction, for directed and random programs.
module tb_sequenciador_instrucoes;

  localparam int AW    = 2;
  localparam int TO    = 5;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          resetn;
  logic          start;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_data;
  logic [15:0]   din;
  logic          run;
  logic          done;
  logic          busy;
  logic          halted;
  logic          erro;
  logic [7:0]    instr_count;

  logic [15:0]   rom [0:DEPTH-1];

  int            n_vec;
  int            n_err;

  // Model state
  logic [AW-1:0] m_pc;
  logic [7:0]    m_cnt;
  logic [15:0]   m_din;

  sequenciador_instrucoes #(
    .ADDR_W (AW),
    .TIMEOUT(TO)
  ) dut (
    .Clock     (clk),
    .Resetn    (resetn),
    .Start     (start),
    .MemAddr   (mem_addr),
    .MemData   (mem_data),
    .DIN       (din),
    .Run       (run),
    .Done      (done),
    .Busy      (busy),
    .Halted    (halted),
    .Erro      (erro),
    .InstrCount(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous program ROM: data valid one cycle after the address
  always @(posedge clk) mem_data <= rom[mem_addr];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    start = 1'b0;
    done  = 1'b0;
  endtask

  // Start/Done activity that must be ignored in the current state
  task automatic noise(input bit en);
    if (en) begin
      start = ($urandom_range(0, 1) == 1);
      done  = ($urandom_range(0, 1) == 1);
    end
  endtask

  // Start the program from a halted/idle/error DUT and follow it instruction by
  // instruction. fixed_lat>0 fixes the Done latency; the max_instr-th
  // instruction never gets Done, ending the program in the error state.
  task automatic run_program(input int max_instr, input int fixed_lat, input bit en_noise);
    logic [15:0]   instr;
    logic [15:0]   exp_din;
    logic [AW-1:0] nxt;
    logic [2:0]    op;
    int            lat;
    m_pc   = '0;
    m_cnt  = '0;
    start  = 1'b1;
    step();
    for (int n = 0; n < max_instr; n++) begin
      // FETCH
      nxt = m_pc + AW'(1);
      check_eq("fetch_busy", busy, 1);
      check_eq("fetch_addr", mem_addr, m_pc);
      check_eq("fetch_flags", {halted, erro, run}, 0);
      check_eq("fetch_count", instr_count, m_cnt);
      noise(en_noise);
      step();
      // LOAD
      check_eq("load_busy", busy, 1);
      check_eq("load_addr", mem_addr, nxt);
      check_eq("load_run", run, 0);
      noise(en_noise);
      step();
      instr = rom[m_pc];
      op    = instr[8:6];
      if (op == 3'b111) begin
        check_eq("halt_flag", halted, 1);
        check_eq("halt_other", {busy, erro, run}, 0);
        check_eq("halt_pc", mem_addr, m_pc);
        check_eq("halt_count", instr_count, m_cnt);
        check_eq("halt_din", din, m_din);
        $display("halt  pc=%0d count=%0d", m_pc, m_cnt);
        return;
      end
      // ISSUE
      check_eq("issue_run", run, 1);
      check_eq("issue_din", din, instr);
      check_eq("issue_busy", busy, 1);
      noise(en_noise);
      step();
      exp_din = (op == 3'b001) ? rom[nxt] : instr;
      m_din   = exp_din;
      m_pc    = m_pc + ((op == 3'b001) ? AW'(2) : AW'(1));
      if (n == max_instr - 1)               lat = 0;
      else if (fixed_lat > 0)               lat = fixed_lat;
      else if ($urandom_range(0, 15) == 0)  lat = 0;
      else                                  lat = $urandom_range(1, TO);
      // EXEC: lat==0 means Done never comes
      for (int k = 1; k <= TO; k++) begin
        check_eq("exec_run", run, 0);
        check_eq("exec_din", din, exp_din);
        check_eq("exec_state", {busy, erro, halted}, 3'b100);
        done  = (k == lat);
        start = en_noise && ($urandom_range(0, 1) == 1);
        step();
        if (k == lat) break;
      end
      $display("instr word=%h din=%h lat=%0d next_pc=%0d", instr, exp_din, lat, m_pc);
      if (lat == 0) begin
        check_eq("erro_flag", erro, 1);
        check_eq("erro_other", {busy, halted, run}, 0);
        check_eq("erro_count", instr_count, m_cnt);
        check_eq("erro_din", din, m_din);
        return;
      end
      m_cnt = m_cnt + 8'd1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w;
    n_vec  = 0;
    n_err  = 0;
    resetn = 1'b0;
    start  = 1'b0;
    done   = 1'b0;
    m_din  = '0;
    for (int i = 0; i < DEPTH; i++) rom[i] = 16'h0008;
    repeat (2) @(negedge clk);
    check_eq("rst_outputs", {busy, halted, erro, run}, 0);
    check_eq("rst_din", din, 0);
    check_eq("rst_addr", mem_addr, 0);
    check_eq("rst_count", instr_count, 0);
    resetn = 1'b1;
    step();
    check_eq("idle_stays", busy, 0);

    // mv then halt, Done two cycles after Run
    rom[0] = 16'h0008; rom[1] = 16'h01C0;
    run_program(10, 2, 1'b0);

    // mvi with immediate, then halt at address 2
    rom[0] = 16'h0050; rom[1] = 16'h1234; rom[2] = 16'h01C0;
    run_program(10, 1, 1'b0);

    // Timeout on the first instruction, then restart
    rom[0] = 16'h0008;
    run_program(1, 0, 1'b0);

    // Done on the very cycle the timeout expires
    rom[0] = 16'h0008; rom[1] = 16'h01C0;
    run_program(10, TO, 1'b0);

    // mvi at the last address takes its immediate from address 0
    rom[0] = 16'h00AA; rom[1] = 16'h0008; rom[2] = 16'h0008; rom[3] = 16'h0050;
    run_program(5, 1, 1'b0);

    // InstrCount wraps past 255
    for (int i = 0; i < DEPTH; i++) rom[i] = 16'h0008;
    run_program(258, 1, 1'b0);

    // Reset in the middle of EXEC, with Start pulses that must be ignored
    start = 1'b1;
    step();
    repeat (3) step();
    done = 1'b1;
    step();
    repeat (3) step();
    check_eq("mid_busy", busy, 1);
    check_eq("mid_count", instr_count, 1);
    start = 1'b1;
    step();
    check_eq("exec_start_ign", {busy, run, erro}, 3'b100);
    resetn = 1'b0;
    #1;
    check_eq("rst_not_async", busy, 1);
    check_eq("rst_not_async_din", din, 16'h0008);
    @(negedge clk);
    check_eq("mrst_outputs", {busy, halted, erro, run}, 0);
    check_eq("mrst_din", din, 0);
    check_eq("mrst_addr", mem_addr, 0);
    check_eq("mrst_count", instr_count, 0);
    resetn = 1'b1;
    m_din  = '0;
    repeat (3) begin
      step();
      check_eq("post_rst_idle", {busy, run}, 0);
    end

    // Random programs with ignored Start/Done noise
    for (int p = 0; p < 40; p++) begin
      for (int i = 0; i < DEPTH; i++) begin
        w = 16'($urandom);
        w[8:6] = ($urandom_range(0, 4) == 4) ? 3'b111 : 3'($urandom_range(0, 3));
        rom[i] = w;
      end
      run_program($urandom_range(1, 12), 0, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
